// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the sequential RISC-V core. Each instruction is
// stepped through FETCH, DECODE, EXECUTE, MEM and WB. This block owns every
// state-changing strobe in the datapath (PC, IR, data memory, register file).
// It traps on illegal encodings reported by the decoder, and it also traps on
// memory handshakes that take too long.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  FETCH   | request instruction word, load IR on imem_ready
//  DECODE  | latch decoder control bits, trap on invalid encodings
//  EXECUTE | resolve branches, route to MEM or WB
//  MEM     | data access, held until dmem_ready (store retires here)
//  WB      | register file write, PC+4, retire
//  TRAP    | halted with error_code; only rst_n leaves
//
// Ports:
//   clk, rst_n           clock / async active-low reset
//   imem_ready           instruction word valid this cycle
//   dmem_ready           data access complete this cycle
//   RegWrite..Branch     decoder control outputs (sampled in DECODE)
//   invOp..invRegAddr    decoder error flags (sampled in DECODE)
//   branch_taken         ALU compare result (sampled in EXECUTE)
//   imem_req, ir_write   fetch request / IR load
//   dmem_req, dmem_we    data request / write qualifier
//   rf_we, wb_sel        register write enable / writeback source (1 = mem)
//   pc_write, pc_src     PC update / source (1 = branch target)
//   halted, error_code   trap indication and cause
//   cycle_count, instret free-running cycle and retired-instruction counters
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    input  logic             Branch,
    input  logic             invOp,
    input  logic             invFunc,
    input  logic             invRegAddr,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             pc_write,
    output logic             pc_src,
    output logic             halted,
    output logic [2:0]       error_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] ERR_INV_OP   = 3'd1;
    localparam logic [2:0] ERR_INV_FUNC = 3'd2;
    localparam logic [2:0] ERR_INV_REG  = 3'd3;
    localparam logic [2:0] ERR_IMEM_TMO = 3'd4;
    localparam logic [2:0] ERR_DMEM_TMO = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t           state, state_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
    logic [2:0]       error_code_next;
    logic             retire;
    logic             ready_in_state;

    logic ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_memto_reg, ctl_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            tmo_cnt       <= TMO_LOAD;
            error_code    <= 3'd0;
            cycle_count   <= '0;
            instret       <= '0;
            ctl_reg_write <= 1'b0;
            ctl_mem_read  <= 1'b0;
            ctl_mem_write <= 1'b0;
            ctl_memto_reg <= 1'b0;
            ctl_branch    <= 1'b0;
        end else begin
            state       <= state_next;
            tmo_cnt     <= tmo_cnt_next;
            error_code  <= error_code_next;
            cycle_count <= cycle_count + CNT_W'(1);
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            if (state == S_DECODE) begin
                ctl_reg_write <= RegWrite;
                ctl_mem_read  <= MemRead;
                ctl_mem_write <= MemWrite;
                ctl_memto_reg <= MemtoReg;
                ctl_branch    <= Branch;
            end
        end
    end

    // Timeout down-counter: reloaded on every state change and on any ready
    // seen in the waiting state; terminal count 0 on a non-ready cycle is the
    // MEM_TIMEOUT-th consecutive miss.
    always_comb begin
        tmo_cnt_next = tmo_cnt;
        if ((state_next != state) || ready_in_state) begin
            tmo_cnt_next = TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt_next = tmo_cnt - TMO_W'(1);
        end
    end

    always_comb begin
        state_next      = state;
        error_code_next = error_code;
        retire          = 1'b0;
        ready_in_state  = 1'b0;
        imem_req        = 1'b0;
        ir_write        = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        rf_we           = 1'b0;
        wb_sel          = 1'b0;
        pc_write        = 1'b0;
        pc_src          = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req       = 1'b1;
                ready_in_state = imem_ready;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_cnt == '0) begin
                    state_next      = S_TRAP;
                    error_code_next = ERR_IMEM_TMO;
                end
            end
            S_DECODE: begin
                if (invOp) begin
                    state_next      = S_TRAP;
                    error_code_next = ERR_INV_OP;
                end else if (invFunc) begin
                    state_next      = S_TRAP;
                    error_code_next = ERR_INV_FUNC;
                end else if (invRegAddr) begin
                    state_next      = S_TRAP;
                    error_code_next = ERR_INV_REG;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (ctl_branch) begin
                    pc_write   = 1'b1;
                    pc_src     = branch_taken;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (ctl_mem_read || ctl_mem_write) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                // A write wins when both MemRead and MemWrite were latched.
                dmem_req       = 1'b1;
                dmem_we        = ctl_mem_write;
                ready_in_state = dmem_ready;
                if (dmem_ready) begin
                    if (ctl_mem_write) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (tmo_cnt == '0) begin
                    state_next      = S_TRAP;
                    error_code_next = ERR_DMEM_TMO;
                end
            end
            S_WB: begin
                rf_we      = ctl_reg_write;
                wb_sel     = ctl_memto_reg;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // The state register already sits in FETCH while reset is held; keep
        // every strobe quiet until reset is released.
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_write = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = 1'b0;
            pc_write = 1'b0;
            pc_src   = 1'b0;
        end
    end

    assign halted = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        MemtoReg = 1'b0, Branch = 1'b0;
    logic        invOp = 1'b0, invFunc = 1'b0, invRegAddr = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_req, ir_write, dmem_req, dmem_we, rf_we, wb_sel;
    logic        pc_write, pc_src, halted;
    logic [2:0]  error_code;
    logic [31:0] cycle_count, instret;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .Branch       (Branch),
        .invOp        (invOp),
        .invFunc      (invFunc),
        .invRegAddr   (invRegAddr),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .ir_write     (ir_write),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .halted       (halted),
        .error_code   (error_code),
        .cycle_count  (cycle_count),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        imem_ready = 0; dmem_ready = 0;
        RegWrite = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; Branch = 0;
        invOp = 0; invFunc = 0; invRegAddr = 0; branch_taken = 0;
    endtask

    // Leaves the bench just after the rising edge that starts cycle 1.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error_code", error_code, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_instret", instret, 0);
        chk("rst_pc_write", pc_write, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ALU op, zero-wait fetch: 4 cycles per instruction
        do_reset();
        RegWrite = 1; imem_ready = 1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("add_rf_we", rf_we, (c % 4 == 0));
            chk("add_pc_write", pc_write, (c % 4 == 0));
            chk("add_ir_write", ir_write, (c % 4 == 1));
            chk("add_pc_src", pc_src, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("add_instret", instret, 3);
        chk("add_cycle_count", cycle_count, 12);

        // Load, dmem_ready arrives after 3 wait cycles: 8 cycles total
        do_reset();
        RegWrite = 1; MemRead = 1; MemtoReg = 1;
        for (int c = 1; c <= 8; c++) begin
            imem_ready = (c == 1);
            dmem_ready = (c == 7);
            @(negedge clk);
            chk("ld_dmem_req", dmem_req, (c >= 4 && c <= 7));
            chk("ld_dmem_we", dmem_we, 0);
            chk("ld_rf_we", rf_we, (c == 8));
            chk("ld_wb_sel", wb_sel, (c == 8));
            chk("ld_pc_write", pc_write, (c == 8));
            next_cycle();
        end
        imem_ready = 0; dmem_ready = 0;
        @(negedge clk);
        chk("ld_instret", instret, 1);
        chk("ld_cycle_count", cycle_count, 8);
        chk("ld_back_to_fetch", imem_req, 1);

        // Two branches: taken, then not taken; 3 cycles each
        do_reset();
        Branch = 1; imem_ready = 1;
        for (int c = 1; c <= 6; c++) begin
            branch_taken = (c <= 3);
            @(negedge clk);
            chk("br_pc_write", pc_write, (c == 3 || c == 6));
            chk("br_pc_src", pc_src, (c == 3));
            chk("br_rf_we", rf_we, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("br_instret", instret, 2);

        // invFunc and invRegAddr together: invFunc has priority
        do_reset();
        imem_ready = 1; invFunc = 1; invRegAddr = 1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            chk("inv_halted", halted, (c >= 3));
            chk("inv_error_code", error_code, (c >= 3) ? 2 : 0);
            chk("inv_imem_req", imem_req, (c == 1));
            chk("inv_pc_write", pc_write, 0);
            chk("inv_cycle_count", cycle_count, c - 1);
            next_cycle();
        end
        chk("inv_instret", instret, 0);

        // Instruction fetch timeout: halted on cycle 17
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk("tmo_halted", halted, (c == 17));
            chk("tmo_imem_req", imem_req, (c <= 16));
            chk("tmo_error_code", error_code, (c == 17) ? 4 : 0);
            next_cycle();
        end
        do_reset();
        imem_ready = 1;
        @(negedge clk);
        chk("tmo_resume_imem_req", imem_req, 1);
        chk("tmo_resume_ir_write", ir_write, 1);
        chk("tmo_resume_halted", halted, 0);

        // Zero-wait store: 4 cycles, no register write
        do_reset();
        MemWrite = 1;
        for (int c = 1; c <= 4; c++) begin
            imem_ready = (c == 1);
            dmem_ready = (c == 4);
            @(negedge clk);
            chk("st_dmem_req", dmem_req, (c == 4));
            chk("st_dmem_we", dmem_we, (c == 4));
            chk("st_pc_write", pc_write, (c == 4));
            chk("st_rf_we", rf_we, 0);
            next_cycle();
        end
        dmem_ready = 0;
        @(negedge clk);
        chk("st_instret", instret, 1);
        chk("st_cycle_count", cycle_count, 4);

        // Store abandoned by reset while waiting in MEM
        do_reset();
        MemWrite = 1;
        for (int c = 1; c <= 4; c++) begin
            imem_ready = (c == 1);
            @(negedge clk);
            chk("strst_dmem_req", dmem_req, (c == 4));
            chk("strst_dmem_we", dmem_we, (c == 4));
            next_cycle();
        end
        #2;
        rst_n = 0;
        dmem_ready = 1;
        #1;
        chk("strst_dmem_req_drop", dmem_req, 0);
        chk("strst_pc_write", pc_write, 0);
        chk("strst_instret_in_rst", instret, 0);
        next_cycle();
        rst_n = 1;
        dmem_ready = 0;
        MemWrite = 0;
        @(negedge clk);
        chk("strst_instret", instret, 0);
        chk("strst_imem_req", imem_req, 1);
        chk("strst_cycle_count", cycle_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
